uart_rx: RTL

- UART receiver; the consuming stage for the transmitter's serial line (`s_data`).
- Oversamples the asynchronous `rx_in` line and detects a start bit with glitch rejection.
- Recovers `DWIDTH` data bits LSB-first using 3-sample majority voting, then checks the optional parity bit and the stop bit.
- Presents the recovered word in parallel with a one-cycle valid pulse and error flags.
- Frame format matches the transmitter: start(0), data LSB-first, optional parity, stop(1); `parity_type` 0 = even, 1 = odd.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: serial line, frame config in, recovered word and status out.
interface uart_rx_if #(
  parameter int unsigned DWIDTH = 8
);
  logic              rx_in;
  logic              parity_en;
  logic              parity_type;
  logic [DWIDTH-1:0] p_data;
  logic              data_valid;
  logic              parity_err;
  logic              stop_err;
  logic              busy;

  modport master (
    output rx_in, parity_en, parity_type,
    input  p_data, data_valid, parity_err, stop_err, busy
  );

  modport slave (
    input  rx_in, parity_en, parity_type,
    output p_data, data_valid, parity_err, stop_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-edge detection with glitch rejection, 3-sample majority
// voting per bit, optional even/odd parity check and stop-bit check with one-cycle status pulses.
module uart_rx #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned OVERSAMPLE = 8
) (
  input logic         clk,
  input logic         rst,
  uart_rx_if.slave    bus
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntSamp0 = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntSamp1 = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] CntVote  = CntW'(OVERSAMPLE / 2 + 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DWIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic              rx_p_q, rx_p_d;
  logic [CntW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]        samp_q, samp_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_type_q, par_type_d;
  logic              par_bad_q, par_bad_d;
  logic [DWIDTH-1:0] p_data_q, p_data_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              stop_err_q, stop_err_d;
  logic              busy_q, busy_d;

  logic rx_s;
  logic maj;
  logic is_last;
  logic is_vote;

  assign rx_s    = sync_q[1];
  // Third vote is the live sample, so the bit resolves on the cycle it is taken.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign is_last = (edge_cnt_q == CntLast);
  assign is_vote = (edge_cnt_q == CntVote);

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], bus.rx_in};
    rx_p_d       = rx_s;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_type_d   = par_type_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    stop_err_d   = 1'b0;

    if (state_q != StIdle) begin
      edge_cnt_d = is_last ? '0 : edge_cnt_q + CntW'(1);
      if (edge_cnt_q == CntSamp0) samp_d[0] = rx_s;
      if (edge_cnt_q == CntSamp1) samp_d[1] = rx_s;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_p_q && !rx_s) begin
          state_d    = StStart;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          par_en_d   = bus.parity_en;
          par_type_d = bus.parity_type;
          par_bad_d  = 1'b0;
        end
      end
      StStart: begin
        if (is_vote && maj) begin
          state_d    = StIdle;
          edge_cnt_d = '0;
        end else if (is_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (is_vote) shift_d = {maj, shift_q[DWIDTH-1:1]};
        if (is_last) begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (is_vote) par_bad_d = (maj != (^shift_q ^ par_type_q));
        if (is_last) state_d = StStop;
      end
      StStop: begin
        // Leave at the last sample so a back-to-back start edge is never missed.
        if (is_vote) begin
          state_d      = StIdle;
          edge_cnt_d   = '0;
          parity_err_d = par_bad_q;
          stop_err_d   = !maj;
          if (maj && !par_bad_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sync_q       <= 2'b11;
      rx_p_q       <= 1'b1;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      stop_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rx_p_q       <= rx_p_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_type_q   <= par_type_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      stop_err_q   <= stop_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.stop_err   = stop_err_q;
  assign bus.busy       = busy_q;

endmodule
